// File: rtl/event_header_sequencer_pkg.sv
// Shared constants for the event header sequencer: header word addresses,
// FSM encoding and the packed trigger-snapshot width.
package event_header_sequencer_pkg;

  localparam logic [5:0] A_TRIG   = 6'h00;
  localparam logic [5:0] A_COUNT  = 6'h01;
  localparam logic [5:0] A_CLK_LO = 6'h02;
  localparam logic [5:0] A_CLK_HI = 6'h03;
  localparam logic [5:0] A_PPS    = 6'h04;
  localparam logic [5:0] A_PAT0   = 6'h06;
  localparam logic [5:0] A_ID_LO  = 6'h10;
  localparam logic [5:0] A_ID_HI  = 6'h11;
  localparam logic [5:0] A_BUF    = 6'h14;
  localparam logic [5:0] A_STATUS = 6'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_CMD_ISSUE, S_CMD_WAIT, S_CMD_GAP, S_STORE, S_ERROR
  } state_t;

  // snapshot = {clock32, pps16, pattern, status, source4, buffer}
  function automatic int snap_width(input int nbuf, input int pattern_words);
    return $clog2(nbuf) + 4 + nbuf + 16 * pattern_words + 16 + 32;
  endfunction

endpackage

// File: rtl/hdr_snapshot_fifo.sv
// First-word-fall-through snapshot FIFO with level output and synchronous flush.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module hdr_snapshot_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] lvl;
  logic          do_push, do_pop;

  assign full_o  = (lvl == LW'(DEPTH));
  assign empty_o = (lvl == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem[rp];
  assign level_o = lvl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else if (flush_i) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      lvl <= lvl + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wp] <= din_i;
  end

endmodule

// File: rtl/event_header_sequencer.sv
// Queues trigger snapshots, issues the repeated digitize command for each one,
// then streams the event header into the per-buffer event RAM.
module event_header_sequencer
  import event_header_sequencer_pkg::*;
#(
  parameter int NBUF          = 4,
  parameter int PATTERN_WORDS = 2,
  parameter int QDEPTH        = 4,
  parameter int CMD_REPEAT    = 2,
  parameter int CMD_GAP       = 2,
  parameter int CMD_TIMEOUT   = 1023,
  parameter int EPOCH_BITS    = 12,
  localparam int BUF_BITS     = $clog2(NBUF),
  localparam int QLW          = $clog2(QDEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       digitize_i,
  input  logic [BUF_BITS-1:0]        digitize_buffer_i,
  input  logic [3:0]                 digitize_source_i,
  input  logic [NBUF-1:0]            buffer_status_i,
  input  logic [16*PATTERN_WORDS-1:0] pattern_i,
  input  logic [15:0]                pps_time_i,
  input  logic [31:0]                clock_time_i,
  input  logic [EPOCH_BITS-1:0]      epoch_i,
  input  logic                       evid_reset_i,
  input  logic                       err_clear_i,
  output logic                       cmd_start_o,
  output logic [31:0]                cmd_event_id_o,
  output logic [BUF_BITS-1:0]        cmd_buffer_o,
  input  logic                       cmd_busy_i,
  input  logic                       cmd_done_i,
  output logic [BUF_BITS+5:0]        event_addr_o,
  output logic [15:0]                event_dat_o,
  output logic                       event_wr_o,
  output logic                       event_done_o,
  output logic [31:0]                next_id_o,
  output logic [15:0]                event_count_o,
  output logic [QLW-1:0]             queue_level_o,
  output logic                       overflow_o,
  output logic                       event_error_o
);
  localparam int SW     = snap_width(NBUF, PATTERN_WORDS);
  localparam int NWORDS = 9 + PATTERN_WORDS;
  localparam int WI_W   = $clog2(NWORDS);
  localparam int TW     = $clog2(CMD_TIMEOUT + 1);
  localparam int LOW_W  = 32 - EPOCH_BITS;
  localparam logic [TW-1:0]   T_LAST   = TW'(CMD_TIMEOUT - 2);
  localparam logic [3:0]      GAP_LAST = 4'(CMD_GAP == 0 ? 0 : CMD_GAP - 1);
  localparam logic [1:0]      REP_LAST = 2'(CMD_REPEAT - 1);
  localparam logic [WI_W-1:0] W_LAST   = WI_W'(NWORDS - 1);

  state_t state, state_d;
  logic [1:0]      rep;
  logic [3:0]      gcnt;
  logic [TW-1:0]   tcnt;
  logic [WI_W-1:0] widx;
  logic [31:0]     next_id;
  logic [15:0]     event_count;
  logic            ovf_q;

  logic [SW-1:0]   snap_in, snap;
  logic            q_full, q_empty, pop, push_req, last_word, more;
  logic [5:0]      w_addr;
  logic [15:0]     w_dat;

  logic [BUF_BITS-1:0]        s_buf;
  logic [3:0]                 s_src;
  logic [NBUF-1:0]            s_status;
  logic [16*PATTERN_WORDS-1:0] s_pat;
  logic [15:0]                s_pps;
  logic [31:0]                s_clk;

  assign snap_in = {clock_time_i, pps_time_i, pattern_i, buffer_status_i,
                    digitize_source_i, digitize_buffer_i};
  assign {s_clk, s_pps, s_pat, s_status, s_src, s_buf} = snap;

  // Triggers are ignored outright while in ERROR, so they never count as drops.
  assign push_req = digitize_i && (state != S_ERROR);

  hdr_snapshot_fifo #(.W(SW), .DEPTH(QDEPTH), .LW(QLW)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (state == S_ERROR && err_clear_i),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (snap_in),
    .dout_o  (snap),
    .level_o (queue_level_o),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign last_word = (widx == W_LAST);
  assign more      = (rep != REP_LAST);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE:      if (!q_empty) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!cmd_busy_i) state_d = S_CMD_ISSUE;
      S_CMD_ISSUE: state_d = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (cmd_done_i) begin
          if (!more)             state_d = S_STORE;
          else if (CMD_GAP == 0) state_d = S_CMD_ISSUE;
          else                   state_d = S_CMD_GAP;
        end else if (tcnt == T_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_CMD_GAP:   if (gcnt == GAP_LAST) state_d = S_CMD_ISSUE;
      S_STORE: begin
        if (last_word) begin
          state_d = S_IDLE;
          pop     = 1'b1;
        end
      end
      S_ERROR:     if (err_clear_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      rep         <= '0;
      gcnt        <= '0;
      tcnt        <= '0;
      widx        <= '0;
      next_id     <= '0;
      event_count <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state <= state_d;
      ovf_q <= push_req && q_full && !pop;
      unique case (state)
        S_IDLE: begin
          rep  <= '0;
          widx <= '0;
        end
        S_CMD_ISSUE: begin
          tcnt <= '0;
          if (rep == '0) event_count <= event_count + 16'd1;
        end
        S_CMD_WAIT: begin
          tcnt <= tcnt + 1'b1;
          gcnt <= '0;
          if (cmd_done_i && more && CMD_GAP == 0) rep <= rep + 2'd1;
        end
        S_CMD_GAP: begin
          gcnt <= gcnt + 4'd1;
          if (gcnt == GAP_LAST) rep <= rep + 2'd1;
        end
        S_STORE: widx <= widx + 1'b1;
        default: ;
      endcase
      // A reload requested in the done cycle wins over the increment.
      if (evid_reset_i)
        next_id <= {epoch_i, LOW_W'(0)};
      else if (state == S_STORE && last_word)
        next_id <= {epoch_i, next_id[LOW_W-1:0] + 1'b1};
    end
  end

  always_comb begin
    int w, pc, held;
    w  = int'(widx);
    pc = 0;
    for (int i = 0; i < NBUF; i++) pc = pc + int'(s_status[i]);
    held   = pc - int'(s_status[s_buf]);
    w_addr = A_BUF;
    w_dat  = 16'(s_buf);
    if (w == 0) begin
      w_addr = A_ID_LO;  w_dat = next_id[15:0];
    end else if (w == 1) begin
      w_addr = A_ID_HI;  w_dat = next_id[31:16];
    end else if (w == 2) begin
      w_addr = A_STATUS; w_dat = 16'(s_status);
    end else if (w == 3) begin
      w_addr = A_COUNT;  w_dat = event_count;
    end else if (w < 4 + PATTERN_WORDS) begin
      w_addr = A_PAT0 + 6'(w - 4);
      w_dat  = s_pat[(w-4)*16 +: 16];
    end else if (w == 4 + PATTERN_WORDS) begin
      w_addr = A_PPS;    w_dat = s_pps;
    end else if (w == 5 + PATTERN_WORDS) begin
      w_addr = A_CLK_LO; w_dat = s_clk[15:0];
    end else if (w == 6 + PATTERN_WORDS) begin
      w_addr = A_CLK_HI; w_dat = s_clk[31:16];
    end else if (w == 7 + PATTERN_WORDS) begin
      w_addr = A_TRIG;   w_dat = {4'h0, 4'(held), 4'(s_buf), s_src};
    end
  end

  assign cmd_start_o    = (state == S_CMD_ISSUE);
  assign cmd_buffer_o   = (state inside {S_CMD_ISSUE, S_CMD_WAIT, S_CMD_GAP})
                          ? s_buf + BUF_BITS'(rep) : '0;
  assign cmd_event_id_o = next_id;
  assign event_wr_o     = (state == S_STORE);
  assign event_addr_o   = event_wr_o ? {s_buf, w_addr} : '0;
  assign event_dat_o    = event_wr_o ? w_dat : '0;
  assign event_done_o   = event_wr_o && last_word;
  assign next_id_o      = next_id;
  assign event_count_o  = event_count;
  assign overflow_o     = ovf_q;
  assign event_error_o  = (state == S_ERROR);

endmodule

// File: tb/tb_event_header_sequencer.sv
// Scoreboard bench: dut0 uses default parameters, dut1 uses 4 pattern words,
// 3 commands with no gap and a 4-bit ID low field so the wrap is reachable.
module tb_event_header_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic dig0 = 0, dig1 = 0, evr0 = 0, evr1 = 0, errc = 0, busy = 0;
  logic done0 = 0, done1 = 0, nodone0 = 0;
  logic [1:0] buf_in = 0;
  logic [3:0] src = 0, status = 0;
  logic [31:0] pattern0 = 0, ck = 0;
  logic [63:0] pattern1 = 0;
  logic [15:0] pps = 0;
  logic [11:0] epoch0 = 0;
  logic [27:0] epoch1 = 0;

  logic start0, start1, wr0, wr1, dn0, dn1, ovf0, ovf1, err0, err1;
  logic [31:0] cid0, cid1, nid0, nid1;
  logic [1:0] cbuf0, cbuf1;
  logic [7:0] addr0, addr1;
  logic [15:0] dat0, dat1, cnt0, cnt1;
  logic [2:0] lvl0, lvl1;

  event_header_sequencer dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .digitize_i(dig0), .digitize_buffer_i(buf_in),
    .digitize_source_i(src), .buffer_status_i(status), .pattern_i(pattern0),
    .pps_time_i(pps), .clock_time_i(ck), .epoch_i(epoch0), .evid_reset_i(evr0),
    .err_clear_i(errc), .cmd_start_o(start0), .cmd_event_id_o(cid0),
    .cmd_buffer_o(cbuf0), .cmd_busy_i(busy), .cmd_done_i(done0),
    .event_addr_o(addr0), .event_dat_o(dat0), .event_wr_o(wr0), .event_done_o(dn0),
    .next_id_o(nid0), .event_count_o(cnt0), .queue_level_o(lvl0),
    .overflow_o(ovf0), .event_error_o(err0));

  event_header_sequencer #(.PATTERN_WORDS(4), .CMD_REPEAT(3), .CMD_GAP(0),
                           .EPOCH_BITS(28)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .digitize_i(dig1), .digitize_buffer_i(buf_in),
    .digitize_source_i(src), .buffer_status_i(status), .pattern_i(pattern1),
    .pps_time_i(pps), .clock_time_i(ck), .epoch_i(epoch1), .evid_reset_i(evr1),
    .err_clear_i(errc), .cmd_start_o(start1), .cmd_event_id_o(cid1),
    .cmd_buffer_o(cbuf1), .cmd_busy_i(busy), .cmd_done_i(done1),
    .event_addr_o(addr1), .event_dat_o(dat1), .event_wr_o(wr1), .event_done_o(dn1),
    .next_id_o(nid1), .event_count_o(cnt1), .queue_level_o(lvl1),
    .overflow_o(ovf1), .event_error_o(err1));

  int total = 0, bad = 0, cyc = 0;
  int ovf_cnt0 = 0, dn_cnt0 = 0, wr_cnt0 = 0;
  logic [24:0] wq0[$], wq1[$];   // {buf, addr, data, done}
  logic [33:0] cq0[$], cq1[$];   // {cmd_buffer, event_id}
  logic [24:0] ew0, ew1;
  logic [33:0] ec0, ec1;
  logic [31:0] mid [2];
  logic [15:0] mcnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  // cmd_done arrives 5 cycles after each start
  always begin
    @(negedge clk);
    if (start0 === 1'b1 && !nodone0) begin
      repeat (5) @(posedge clk);
      #1 done0 = 1;
      @(posedge clk);
      #1 done0 = 0;
    end
  end
  always begin
    @(negedge clk);
    if (start1 === 1'b1) begin
      repeat (5) @(posedge clk);
      #1 done1 = 1;
      @(posedge clk);
      #1 done1 = 0;
    end
  end

  always @(negedge clk) begin
    if (wr0 === 1'b1) begin
      total++; wr_cnt0++;
      if (wq0.size() == 0) begin
        bad++; $display("FAIL hdr0_unexpected got addr=%h dat=%h done=%b", addr0, dat0, dn0);
      end else begin
        ew0 = wq0.pop_front();
        if ({addr0, dat0, dn0} !== ew0) begin
          bad++; $display("FAIL hdr0_word got=%h want=%h", {addr0, dat0, dn0}, ew0);
        end
      end
    end
    if (dn0 === 1'b1) dn_cnt0++;
    if (ovf0 === 1'b1) ovf_cnt0++;
    if (start0 === 1'b1) begin
      total++;
      if (cq0.size() == 0) begin
        bad++; $display("FAIL cmd0_unexpected got buf=%0d id=%h", cbuf0, cid0);
      end else begin
        ec0 = cq0.pop_front();
        if ({cbuf0, cid0} !== ec0) begin
          bad++; $display("FAIL cmd0 got=%h want=%h", {cbuf0, cid0}, ec0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      total++;
      if (wq1.size() == 0) begin
        bad++; $display("FAIL hdr1_unexpected got addr=%h dat=%h done=%b", addr1, dat1, dn1);
      end else begin
        ew1 = wq1.pop_front();
        if ({addr1, dat1, dn1} !== ew1) begin
          bad++; $display("FAIL hdr1_word got=%h want=%h", {addr1, dat1, dn1}, ew1);
        end
      end
    end
    if (start1 === 1'b1) begin
      total++;
      if (cq1.size() == 0) begin
        bad++; $display("FAIL cmd1_unexpected got buf=%0d id=%h", cbuf1, cid1);
      end else begin
        ec1 = cq1.pop_front();
        if ({cbuf1, cid1} !== ec1) begin
          bad++; $display("FAIL cmd1 got=%h want=%h", {cbuf1, cid1}, ec1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model of one accepted event: expected commands and header words.
  task automatic hdr(input bit d, input logic [1:0] b, input logic [3:0] s,
                     input logic [3:0] st, input logic [63:0] pat,
                     input logic [15:0] pv, input logic [31:0] cv, input bit words);
    int pw, rp, held, ncmd;
    logic [31:0] id;
    logic [15:0] cnt;
    logic [1:0]  cb;
    logic [24:0] ent;
    logic [5:0]  a[$];
    logic [15:0] v[$];
    pw = d ? 4 : 2;
    rp = d ? 3 : 2;
    id = mid[d];
    mcnt[d] = mcnt[d] + 16'd1;
    cnt = mcnt[d];
    held = int'(st[0]) + int'(st[1]) + int'(st[2]) + int'(st[3]) - int'(st[b]);
    ncmd = words ? rp : 1;
    for (int r = 0; r < ncmd; r++) begin
      cb = b + 2'(r);
      if (d) cq1.push_back({cb, id}); else cq0.push_back({cb, id});
    end
    if (words) begin
      a.push_back(6'h10); v.push_back(id[15:0]);
      a.push_back(6'h11); v.push_back(id[31:16]);
      a.push_back(6'h15); v.push_back({12'h0, st});
      a.push_back(6'h01); v.push_back(cnt);
      for (int k = 0; k < pw; k++) begin
        a.push_back(6'h06 + 6'(k)); v.push_back(pat[16*k +: 16]);
      end
      a.push_back(6'h04); v.push_back(pv);
      a.push_back(6'h02); v.push_back(cv[15:0]);
      a.push_back(6'h03); v.push_back(cv[31:16]);
      a.push_back(6'h00); v.push_back({4'h0, 4'(held), 2'b00, b, s});
      a.push_back(6'h14); v.push_back({14'h0, b});
      for (int i = 0; i < a.size(); i++) begin
        ent = {b, a[i], v[i], (i == a.size() - 1)};
        if (d) wq1.push_back(ent); else wq0.push_back(ent);
      end
      if (d) mid[1] = {epoch1, mid[1][3:0] + 4'd1};
      else   mid[0] = {epoch0, mid[0][19:0] + 20'd1};
    end
  endtask

  task automatic trig(input bit d, input logic [1:0] b, input logic [3:0] s,
                      input logic [3:0] st, input logic [63:0] pat,
                      input bit accept, input bit words);
    buf_in = b; src = s; status = st;
    pattern0 = pat[31:0]; pattern1 = pat;
    pps = 16'($urandom); ck = $urandom;
    if (d) dig1 = 1; else dig0 = 1;
    if (accept) hdr(d, b, s, st, pat, pps, ck, words);
    tick();
    dig0 = 0; dig1 = 0;
  endtask

  task automatic drain(input bit d, input int budget);
    int n;
    n = 0;
    while (((d ? wq1.size() : wq0.size()) != 0 || (d ? cq1.size() : cq0.size()) != 0)
           && n < budget) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= budget) begin
      bad++; $display("FAIL drain%0d words_left=%0d required=0", d, d ? wq1.size() : wq0.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    total++;
    if ({start0, cid0, cbuf0, addr0, dat0, wr0, dn0, nid0, cnt0, lvl0, ovf0, err0} !== '0) begin
      bad++; $display("FAIL reset_outs0 got nonzero id=%h lvl=%0d", nid0, lvl0);
    end
    total++;
    if ({start1, cid1, cbuf1, addr1, dat1, wr1, dn1, nid1, cnt1, lvl1, ovf1, err1} !== '0) begin
      bad++; $display("FAIL reset_outs1 got nonzero id=%h lvl=%0d", nid1, lvl1);
    end
    rst_n = 1;
    tick(); tick();
    total++;
    if ({nid0, lvl0, err0, wr0, start0} !== '0) begin
      bad++; $display("FAIL post_reset0 got id=%h lvl=%0d err=%b", nid0, lvl0, err0);
    end
  endtask

  task automatic test_single_event();
    trig(0, 2'd2, 4'h5, 4'b0110, 64'hDEADBEEF, 1, 1);
    drain(0, 200);
    tick();
    total++;
    if (nid0 !== 32'd1) begin bad++; $display("FAIL single_next_id got=%h want=1", nid0); end
    total++;
    if (cnt0 !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", cnt0); end
    total++;
    if (dn_cnt0 !== 1) begin bad++; $display("FAIL single_done got=%0d want=1", dn_cnt0); end
  endtask

  task automatic test_overflow();
    int ob;
    epoch0 = 0;
    evr0 = 1; tick(); evr0 = 0;
    mid[0] = 32'd0;
    busy = 1; tick();
    ob = ovf_cnt0;
    for (int i = 0; i < 6; i++)
      trig(0, 2'(i), 4'($urandom), 4'($urandom), {32'h0, $urandom}, i < 4, 1);
    tick(); tick();
    total++;
    if (lvl0 !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", lvl0); end
    total++;
    if (ovf_cnt0 - ob !== 2) begin bad++; $display("FAIL ovf_pulses got=%0d want=2", ovf_cnt0 - ob); end
    busy = 0;
    drain(0, 1000);
    tick();
    total++;
    if (nid0 !== 32'd4) begin bad++; $display("FAIL ovf_next_id got=%h want=4", nid0); end
    total++;
    if (lvl0 !== 3'd0) begin bad++; $display("FAIL ovf_drained_level got=%0d want=0", lvl0); end
  endtask

  task automatic test_timeout();
    int n, t0, ob;
    nodone0 = 1;
    trig(0, 2'd1, 4'h3, 4'b0010, 64'h1234, 1, 0);
    n = 0;
    while (start0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (start0 !== 1'b1) begin bad++; $display("FAIL tmo_start got=%b want=1", start0); end
    t0 = cyc;
    n = 0;
    while (err0 !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    total++;
    if (err0 !== 1'b1 || cyc - t0 !== 1023) begin
      bad++; $display("FAIL tmo_latency got=%0d want=1023 err=%b", cyc - t0, err0);
    end
    tick();
    ob = ovf_cnt0;
    trig(0, 2'd0, 4'h1, 4'b0001, 64'h0, 0, 0);
    tick(); tick();
    total++;
    if ({err0, lvl0} !== {1'b1, 3'd1} || ovf_cnt0 != ob) begin
      bad++; $display("FAIL tmo_ignore got err=%b lvl=%0d ovf=%0d want err=1 lvl=1 ovf=0", err0, lvl0, ovf_cnt0 - ob);
    end
    errc = 1; tick(); errc = 0; tick();
    total++;
    if ({err0, lvl0} !== 4'b0) begin bad++; $display("FAIL tmo_clear got err=%b lvl=%0d want 0/0", err0, lvl0); end
    total++;
    if (nid0 !== mid[0] || cnt0 !== mcnt[0]) begin
      bad++; $display("FAIL tmo_keep got id=%h cnt=%0d want id=%h cnt=%0d", nid0, cnt0, mid[0], mcnt[0]);
    end
    nodone0 = 0;
  endtask

  task automatic test_pattern_repeat();
    epoch1 = 28'h1;
    evr1 = 1; tick(); evr1 = 0;
    mid[1] = 32'h10;
    trig(1, 2'd3, 4'hA, 4'b1011, 64'h1111_2222_3333_4444, 1, 1);
    drain(1, 300);
    tick();
    total++;
    if (nid1 !== 32'h11) begin bad++; $display("FAIL pat_next_id got=%h want=00000011", nid1); end
    total++;
    if (cnt1 !== 16'd1) begin bad++; $display("FAIL pat_count got=%0d want=1", cnt1); end
  endtask

  task automatic test_id_wrap();
    int n;
    epoch1 = 28'hABCDEF0;
    for (int i = 0; i < 15; i++) begin
      trig(1, 2'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1, 1);
      drain(1, 300);
    end
    tick();
    total++;
    if (nid1 !== 32'hABCDEF00) begin bad++; $display("FAIL wrap_id got=%h want=abcdef00", nid1); end
    epoch1 = 28'h1234567;
    trig(1, 2'd1, 4'h2, 4'b0100, 64'h5, 1, 1);
    mid[1] = 32'h12345670;
    n = 0;
    while (dn1 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    evr1 = 1;
    @(posedge clk); #1 evr1 = 0;
    total++;
    if (nid1 !== 32'h12345670) begin bad++; $display("FAIL evid_reset_at_done got=%h want=12345670", nid1); end
    drain(1, 50);
  endtask

  task automatic test_reset_mid_store();
    int n, w0, db;
    trig(0, 2'd1, 4'h2, 4'b1111, 64'hCAFE_F00D, 1, 1);
    w0 = wr_cnt0;
    n = 0;
    while (wr_cnt0 - w0 < 3 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst_n = 0;
    wq0.delete(); cq0.delete(); wq1.delete(); cq1.delete();
    mid[0] = 0; mcnt[0] = 0; mid[1] = 0; mcnt[1] = 0;
    db = dn_cnt0;
    #1;
    total++;
    if ({start0, cid0, cbuf0, addr0, dat0, wr0, dn0, nid0, cnt0, lvl0, ovf0, err0} !== '0) begin
      bad++; $display("FAIL midstore_reset got wr=%b addr=%h id=%h lvl=%0d want all 0", wr0, addr0, nid0, lvl0);
    end
    repeat (3) tick();
    rst_n = 1;
    repeat (40) tick();
    total++;
    if (dn_cnt0 !== db) begin bad++; $display("FAIL midstore_done got=%0d want=0", dn_cnt0 - db); end
    total++;
    if ({nid0, cnt0, lvl0} !== '0) begin
      bad++; $display("FAIL midstore_state got id=%h cnt=%0d lvl=%0d want 0", nid0, cnt0, lvl0);
    end
  endtask

  initial begin
    mid[0] = 0; mid[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
    #2 rst_n = 0;
    test_reset();
    test_single_event();
    test_overflow();
    test_timeout();
    test_pattern_repeat();
    test_id_wrap();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
